// File: rtl/pc_unit_pkg.sv
// Shared types and sizing helpers for the program-counter unit and its return stack.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_INC    = 3'd1,
    OP_SKIP   = 3'd2,
    OP_GOTO   = 3'd3,
    OP_CALL   = 3'd4,
    OP_RETURN = 3'd5,
    OP_INT    = 3'd6,
    OP_RSVD   = 3'd7
  } pc_op_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int depth_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Decode-to-PC bus: next-PC request in one direction, address and stack status back.
interface pc_unit_if #(
  parameter int PC_WIDTH    = 13,
  parameter int STACK_DEPTH = 8
);
  import pc_pkg::*;

  localparam int DEPTH_W = depth_width(STACK_DEPTH);

  logic                en;
  pc_op_t              op;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] counter;
  logic [DEPTH_W-1:0]  depth;
  logic                stack_full;
  logic                stack_empty;
  logic                overflow;
  logic                underflow;

  modport master (
    output en, op, target,
    input  counter, depth, stack_full, stack_empty, overflow, underflow
  );

  modport slave (
    input  en, op, target,
    output counter, depth, stack_full, stack_empty, overflow, underflow
  );

endinterface

// File: rtl/pc_unit_return_stack.sv
// Circular return-address LIFO: overwrites the oldest entry when full and
// wraps the pointer when popped empty, recording both events in sticky flags.
module return_stack
  import pc_pkg::*;
#(
  parameter int PC_WIDTH    = 13,
  parameter int STACK_DEPTH = 8,
  localparam int PTR_W      = ptr_width(STACK_DEPTH),
  localparam int DEPTH_W    = depth_width(STACK_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] din,
  output logic [PC_WIDTH-1:0] dout,
  output logic [DEPTH_W-1:0]  depth,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]    sp;
  logic [PTR_W-1:0]    sp_top;

  assign sp_top = sp - PTR_W'(1);
  assign dout   = mem[sp_top];

  // Storage is deliberately left out of reset so it maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[sp] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp        <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      sp <= sp + PTR_W'(1);
      if (depth == FULL_DEPTH) begin
        overflow <= 1'b1;
      end else begin
        depth <= depth + DEPTH_W'(1);
      end
    end else if (pop) begin
      sp <= sp_top;
      if (depth == '0) begin
        underflow <= 1'b1;
      end else begin
        depth <= depth - DEPTH_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: counter register plus next-PC mux for increment,
// skip, goto, call, return and interrupt entry.
module pc_unit
  import pc_pkg::*;
#(
  parameter int PC_WIDTH     = 13,
  parameter int STACK_DEPTH  = 8,
  parameter int RESET_VECTOR = 0,
  parameter int INT_VECTOR   = 4
) (
  input  logic       clk,
  input  logic       reset,
  pc_unit_if.slave   bus
);

  localparam int                  DEPTH_W  = depth_width(STACK_DEPTH);
  localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] INT_PC   = PC_WIDTH'(INT_VECTOR);
  localparam logic [PC_WIDTH-1:0] ONE      = PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0] TWO      = PC_WIDTH'(2);

  logic [PC_WIDTH-1:0] counter_q;
  logic [PC_WIDTH-1:0] counter_d;
  logic [PC_WIDTH-1:0] push_value;
  logic [PC_WIDTH-1:0] pop_value;
  logic                push;
  logic                pop;
  logic [DEPTH_W-1:0]  depth;
  logic                overflow;
  logic                underflow;

  // Interrupt entry saves the current address so the interrupted instruction reruns.
  always_comb begin
    counter_d  = counter_q;
    push_value = counter_q + ONE;
    push       = 1'b0;
    pop        = 1'b0;
    if (bus.en) begin
      case (bus.op)
        OP_INC:    counter_d = counter_q + ONE;
        OP_SKIP:   counter_d = counter_q + TWO;
        OP_GOTO:   counter_d = bus.target;
        OP_CALL: begin
          push      = 1'b1;
          counter_d = bus.target;
        end
        OP_RETURN: begin
          pop       = 1'b1;
          counter_d = pop_value;
        end
        OP_INT: begin
          push       = 1'b1;
          push_value = counter_q;
          counter_d  = INT_PC;
        end
        default:   counter_d = counter_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_q <= RESET_PC;
    end else begin
      counter_q <= counter_d;
    end
  end

  return_stack #(
    .PC_WIDTH    (PC_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (push_value),
    .dout      (pop_value),
    .depth     (depth),
    .overflow  (overflow),
    .underflow (underflow)
  );

  assign bus.counter     = counter_q;
  assign bus.depth       = depth;
  assign bus.stack_full  = (depth == DEPTH_W'(STACK_DEPTH));
  assign bus.stack_empty = (depth == '0);
  assign bus.overflow    = overflow;
  assign bus.underflow   = underflow;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a reference model queues expected state per step,
// and each step's result is popped and compared after the clock edge.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int PC_WIDTH    = 13;
  localparam int STACK_DEPTH = 8;
  localparam int DEPTH_W     = 4;

  typedef struct {
    string               tag;
    logic [PC_WIDTH-1:0] counter;
    logic [DEPTH_W-1:0]  depth;
    logic                full;
    logic                empty;
    logic                ovf;
    logic                unf;
  } expect_t;

  logic clk = 1'b0;
  logic reset;

  int assert_count = 0;
  int fail_count   = 0;

  expect_t scoreboard [$];

  logic [PC_WIDTH-1:0] m_counter;
  logic [PC_WIDTH-1:0] m_mem [STACK_DEPTH];
  int                  m_sp;
  int                  m_depth;
  logic                m_ovf;
  logic                m_unf;

  pc_unit_if #(.PC_WIDTH(PC_WIDTH), .STACK_DEPTH(STACK_DEPTH)) bus ();

  pc_unit #(
    .PC_WIDTH     (PC_WIDTH),
    .STACK_DEPTH  (STACK_DEPTH),
    .RESET_VECTOR (0),
    .INT_VECTOR   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_counter = '0;
    m_sp      = 0;
    m_depth   = 0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
  endtask

  task automatic model_push(input logic [PC_WIDTH-1:0] value);
    m_mem[m_sp] = value;
    m_sp        = (m_sp + 1) % STACK_DEPTH;
    if (m_depth == STACK_DEPTH) m_ovf = 1'b1;
    else m_depth++;
  endtask

  task automatic model_step(input pc_op_t op, input logic [PC_WIDTH-1:0] target);
    case (op)
      OP_INC:  m_counter = m_counter + 13'd1;
      OP_SKIP: m_counter = m_counter + 13'd2;
      OP_GOTO: m_counter = target;
      OP_CALL: begin
        model_push(m_counter + 13'd1);
        m_counter = target;
      end
      OP_RETURN: begin
        m_sp      = (m_sp + STACK_DEPTH - 1) % STACK_DEPTH;
        m_counter = m_mem[m_sp];
        if (m_depth == 0) m_unf = 1'b1;
        else m_depth--;
      end
      OP_INT: begin
        model_push(m_counter);
        m_counter = 13'd4;
      end
      default: ;
    endcase
  endtask

  task automatic push_expect(input string tag);
    expect_t e;
    e.tag     = tag;
    e.counter = m_counter;
    e.depth   = DEPTH_W'(m_depth);
    e.full    = (m_depth == STACK_DEPTH);
    e.empty   = (m_depth == 0);
    e.ovf     = m_ovf;
    e.unf     = m_unf;
    scoreboard.push_back(e);
  endtask

  task automatic check_output();
    expect_t e;
    if (scoreboard.size() == 0) begin
      assert_count++;
      fail_count++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = scoreboard.pop_front();
      check_value({e.tag, ".counter"}, 32'(bus.counter), 32'(e.counter));
      check_value({e.tag, ".depth"}, 32'(bus.depth), 32'(e.depth));
      check_value({e.tag, ".full"}, 32'(bus.stack_full), 32'(e.full));
      check_value({e.tag, ".empty"}, 32'(bus.stack_empty), 32'(e.empty));
      check_value({e.tag, ".overflow"}, 32'(bus.overflow), 32'(e.ovf));
      check_value({e.tag, ".underflow"}, 32'(bus.underflow), 32'(e.unf));
    end
  endtask

  task automatic apply_stimulus(input logic en, input pc_op_t op,
                                input logic [PC_WIDTH-1:0] target, input string tag);
    @(negedge clk);
    bus.en     = en;
    bus.op     = op;
    bus.target = target;
    if (en) model_step(op, target);
    push_expect(tag);
    @(posedge clk);
    #1;
    check_output();
  endtask

  // Asserts reset wherever the caller is in the cycle and checks before any edge.
  task automatic apply_reset(input string tag);
    bus.en = 1'b0;
    reset  = 1'b0;
    model_reset();
    push_expect(tag);
    #1;
    check_output();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.en     = 1'b0;
    bus.op     = OP_HOLD;
    bus.target = '0;
    reset      = 1'b1;
    #2;
    apply_reset("reset");

    repeat (5) apply_stimulus(1'b1, OP_INC, 13'd0, "inc");
    check_value("inc5", 32'(bus.counter), 32'd5);

    apply_stimulus(1'b1, OP_GOTO, 13'd8190, "goto8190");
    apply_stimulus(1'b1, OP_SKIP, 13'd0, "skip_wrap");
    check_value("skip_wrap_const", 32'(bus.counter), 32'd0);
    apply_stimulus(1'b1, OP_GOTO, 13'd8191, "goto8191");
    apply_stimulus(1'b1, OP_INC, 13'd0, "inc_wrap");
    check_value("inc_wrap_const", 32'(bus.counter), 32'd0);

    apply_stimulus(1'b1, OP_GOTO, 13'd100, "goto100");
    apply_stimulus(1'b1, OP_CALL, 13'd200, "call200");
    apply_stimulus(1'b1, OP_CALL, 13'd300, "call300");
    check_value("nest_depth", 32'(bus.depth), 32'd2);
    apply_stimulus(1'b1, OP_RETURN, 13'd0, "ret1");
    check_value("ret1_const", 32'(bus.counter), 32'd201);
    apply_stimulus(1'b1, OP_RETURN, 13'd0, "ret2");
    check_value("ret2_const", 32'(bus.counter), 32'd101);
    check_value("ret2_empty", 32'(bus.stack_empty), 32'd1);
    check_value("ret2_flags", 32'({bus.overflow, bus.underflow}), 32'd0);

    apply_stimulus(1'b1, OP_GOTO, 13'd0, "goto0");
    for (int i = 1; i <= 9; i++) apply_stimulus(1'b1, OP_CALL, 13'(i * 10), "ovf_call");
    check_value("ovf_depth", 32'(bus.depth), 32'd8);
    check_value("ovf_flag", 32'(bus.overflow), 32'd1);
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1'b1, OP_RETURN, 13'd0, "ovf_ret");
      check_value("ovf_ret_const", 32'(bus.counter), 32'(81 - 10 * k));
    end

    @(negedge clk);
    apply_reset("reset2");
    apply_stimulus(1'b1, OP_RETURN, 13'd0, "underflow");
    check_value("unf_flag", 32'(bus.underflow), 32'd1);
    check_value("unf_depth", 32'(bus.depth), 32'd0);
    check_value("unf_counter", 32'(bus.counter), 32'd71);

    apply_stimulus(1'b1, OP_GOTO, 13'd37, "goto37");
    apply_stimulus(1'b1, OP_INT, 13'd0, "int");
    check_value("int_counter", 32'(bus.counter), 32'd4);
    check_value("int_depth", 32'(bus.depth), 32'd1);
    repeat (3) apply_stimulus(1'b0, OP_GOTO, 13'd999, "en_low");
    check_value("en_low_counter", 32'(bus.counter), 32'd4);
    apply_stimulus(1'b1, OP_RETURN, 13'd0, "int_ret");
    check_value("int_ret_const", 32'(bus.counter), 32'd37);
    apply_stimulus(1'b1, OP_RSVD, 13'd555, "reserved");

    apply_stimulus(1'b1, OP_GOTO, 13'd50, "goto50");
    apply_stimulus(1'b1, OP_CALL, 13'd60, "call60");
    apply_stimulus(1'b1, OP_CALL, 13'd70, "call70");
    #1;
    apply_reset("async_reset");
    apply_stimulus(1'b1, OP_CALL, 13'd80, "post_call");
    apply_stimulus(1'b1, OP_RETURN, 13'd0, "post_ret");
    check_value("post_ret_const", 32'(bus.counter), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
